// File: rtl/fsk4_crc_pkg.sv
// rtl/fsk4_crc_pkg.sv - shared tone thresholds, CRC-4 constants and receiver state enum for the 4FSK byte link
package fsk4_crc_pkg;

  localparam int CW_W           = 12;
  localparam int DATA_W         = 8;
  localparam int CRC_W          = 4;
  localparam int SYMS_PER_FRAME = 6;

  localparam logic [CRC_W-1:0] CRC4_POLY = 4'b0011;

  localparam int DEF_SYMBOL_CYCLES = 4096;
  localparam int DEF_THR_01        = 75;
  localparam int DEF_THR_12        = 107;
  localparam int DEF_THR_23        = 149;
  localparam int DEF_MIN_EDGES     = 16;
  localparam int DEF_QUIET_CYCLES  = 256;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE,
    QUIET
  } rx_state_t;

  // Folds one 2-bit symbol into the x^4+x+1 LFSR, MSB first.
  function automatic logic [CRC_W-1:0] crc4_fold2(input logic [CRC_W-1:0] crc,
                                                  input logic [1:0] sym);
    logic [CRC_W-1:0] c;
    c = crc;
    for (int i = 1; i >= 0; i--) begin
      if (c[CRC_W-1] ^ sym[i]) c = {c[CRC_W-2:0], 1'b0} ^ CRC4_POLY;
      else                     c = {c[CRC_W-2:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/fsk4_symbol_slicer.sv
// rtl/fsk4_symbol_slicer.sv - input synchronizer, rising-edge counter per symbol window and tone slicer
module fsk4_symbol_slicer
  import fsk4_crc_pkg::*;
#(
  parameter int SYMBOL_CYCLES = DEF_SYMBOL_CYCLES,
  parameter int THR_01        = DEF_THR_01,
  parameter int THR_12        = DEF_THR_12,
  parameter int THR_23        = DEF_THR_23,
  parameter int MIN_EDGES     = DEF_MIN_EDGES
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       fsk_in,
  input  logic       i_start,
  input  logic       i_run,
  output logic       o_edge,
  output logic [1:0] o_sym,
  output logic       o_sym_valid,
  output logic       o_carrier_lost
);

  localparam int               WIN_W    = $clog2(SYMBOL_CYCLES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SYMBOL_CYCLES - 1);
  localparam logic [7:0]       L_THR_01 = 8'(THR_01);
  localparam logic [7:0]       L_THR_12 = 8'(THR_12);
  localparam logic [7:0]       L_THR_23 = 8'(THR_23);
  localparam logic [7:0]       L_MIN    = 8'(MIN_EDGES);

  logic             r_sync1, r_sync2, r_prev;
  logic [WIN_W-1:0] r_win;
  logic [7:0]       r_count;
  logic             w_edge, w_win_end;
  logic [7:0]       w_total;

  assign w_edge    = r_sync2 & ~r_prev;
  assign w_win_end = i_run && (r_win == WIN_LAST);
  // Edge in the window's last cycle still belongs to that window.
  assign w_total   = (r_count == 8'hFF) ? 8'hFF : r_count + {7'd0, w_edge};

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= fsk_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_win   <= '0;
      r_count <= '0;
    end else if (i_start) begin
      r_win   <= '0;
      r_count <= 8'd1;
    end else if (i_run) begin
      r_win   <= w_win_end ? '0 : r_win + WIN_W'(1);
      r_count <= w_win_end ? '0 : w_total;
    end else begin
      r_win   <= '0;
      r_count <= '0;
    end
  end

  always_comb begin
    o_sym = 2'd3;
    if (w_total < L_THR_01)      o_sym = 2'd0;
    else if (w_total < L_THR_12) o_sym = 2'd1;
    else if (w_total < L_THR_23) o_sym = 2'd2;
  end

  assign o_edge         = w_edge;
  assign o_sym_valid    = w_win_end;
  assign o_carrier_lost = w_win_end && (w_total < L_MIN);

endmodule

// File: rtl/fsk4_crc_receiver.sv
// rtl/fsk4_crc_receiver.sv - 4FSK receive path: frame FSM, codeword assembly and CRC-4 check
module fsk4_crc_receiver
  import fsk4_crc_pkg::*;
#(
  parameter int SYMBOL_CYCLES = DEF_SYMBOL_CYCLES,
  parameter int THR_01        = DEF_THR_01,
  parameter int THR_12        = DEF_THR_12,
  parameter int THR_23        = DEF_THR_23,
  parameter int MIN_EDGES     = DEF_MIN_EDGES,
  parameter int QUIET_CYCLES  = DEF_QUIET_CYCLES
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              fsk_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              crc_ok,
  output logic              frame_err,
  output logic              busy
);

  localparam int                QCNT_W = $clog2(QUIET_CYCLES) + 1;
  localparam logic [QCNT_W-1:0] Q_LAST = QCNT_W'(QUIET_CYCLES - 1);

  rx_state_t         r_state, w_next;
  logic [2:0]        r_idx;
  logic [CW_W-3:0]   r_shift;
  logic [CRC_W-1:0]  r_crc;
  logic [QCNT_W-1:0] r_qcnt;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_crc_ok, r_frame_err;

  logic              w_edge, w_sym_valid, w_carrier_lost, w_start, w_run, w_last_sym;
  logic [1:0]        w_sym;
  logic [CW_W-1:0]   w_shift_next;
  logic [CRC_W-1:0]  w_crc_next;

  assign w_start      = (r_state == IDLE) && w_edge;
  assign w_run        = (r_state == RECV);
  assign w_shift_next = {r_shift, w_sym};
  assign w_crc_next   = crc4_fold2(r_crc, w_sym);
  assign w_last_sym   = (r_idx == 3'(SYMS_PER_FRAME - 1));

  fsk4_symbol_slicer #(
    .SYMBOL_CYCLES(SYMBOL_CYCLES),
    .THR_01       (THR_01),
    .THR_12       (THR_12),
    .THR_23       (THR_23),
    .MIN_EDGES    (MIN_EDGES)
  ) u_slicer (
    .sys_clk       (sys_clk),
    .reset         (reset),
    .fsk_in        (fsk_in),
    .i_start       (w_start),
    .i_run         (w_run),
    .o_edge        (w_edge),
    .o_sym         (w_sym),
    .o_sym_valid   (w_sym_valid),
    .o_carrier_lost(w_carrier_lost)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_edge) w_next = RECV;
      RECV:    if (w_sym_valid && (w_carrier_lost || w_last_sym)) w_next = DONE;
      DONE:    w_next = QUIET;
      QUIET:   if (!w_edge && (r_qcnt == Q_LAST)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Result registers load on the RECV->DONE edge so they are valid during DONE and hold afterwards.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_idx       <= '0;
      r_shift     <= '0;
      r_crc       <= '0;
      r_qcnt      <= '0;
      r_rx_data   <= '0;
      r_crc_ok    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_edge) begin
          r_idx   <= '0;
          r_shift <= '0;
          r_crc   <= '0;
        end
        RECV: if (w_sym_valid) begin
          r_idx   <= r_idx + 3'd1;
          r_shift <= w_shift_next[CW_W-3:0];
          r_crc   <= w_crc_next;
          if (w_carrier_lost) begin
            r_rx_data   <= '0;
            r_crc_ok    <= 1'b0;
            r_frame_err <= 1'b1;
          end else if (w_last_sym) begin
            r_rx_data   <= w_shift_next[CW_W-1:CRC_W];
            r_crc_ok    <= (w_crc_next == '0);
            r_frame_err <= 1'b0;
          end
        end
        DONE:    r_qcnt <= '0;
        QUIET:   r_qcnt <= w_edge ? '0 : r_qcnt + QCNT_W'(1);
        default: r_qcnt <= '0;
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = (r_state == DONE);
  assign crc_ok    = r_crc_ok;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fsk4_crc_receiver.sv
// tb/tb_fsk4_crc_receiver.sv - directed bench for the 4FSK CRC-4 receiver with shortened symbol windows
module tb_fsk4_crc_receiver;

  // Windows shortened 4x; half-periods scaled alike so edges per window match the 4096-cycle tones.
  localparam int SYM   = 1024;
  localparam int QUIET = 256;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       fsk_in;
  logic [7:0] rx_data;
  logic       rx_valid, crc_ok, frame_err, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nvalid = 0;
  int t0 = 0;

  fsk4_crc_receiver #(.SYMBOL_CYCLES(SYM), .QUIET_CYCLES(QUIET)) dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .fsk_in   (fsk_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .crc_ok   (crc_ok),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;
  always @(negedge sys_clk) if (rx_valid === 1'b1) nvalid <= nvalid + 1;

  function automatic logic tone_level(input logic [11:0] cw, input int nsym, input int d);
    int w, c, hp;
    logic [1:0] s;
    w = d / SYM;
    c = d % SYM;
    if (w >= nsym) return 1'b0;
    s = cw[11 - 2*w -: 2];
    case (s)
      2'd0:    hp = 8;
      2'd1:    hp = 6;
      2'd2:    hp = 4;
      default: hp = 3;
    endcase
    return ((c / hp) % 2) == 0;
  endfunction

  function automatic logic count_level(input logic [5:0][7:0] cnt, input int d);
    int w, c, n;
    w = d / SYM;
    c = d % SYM;
    if (w > 5) return 1'b0;
    if (d < 2) return 1'b1;
    n = int'(cnt[w]) - ((w == 0) ? 1 : 0);
    return (c >= 8) && (((c - 8) % 4) < 2) && (((c - 8) / 4) < n);
  endfunction

  task automatic send_tones(input logic [11:0] cw, input int nsym, input int d_from, input int d_to);
    for (int d = d_from; d < d_to; d++) begin
      @(posedge sys_clk); #1;
      if (d == 0) t0 = cyc;
      fsk_in = tone_level(cw, nsym, d);
    end
  endtask

  task automatic send_counts(input logic [5:0][7:0] cnt);
    for (int d = 0; d < 6*SYM; d++) begin
      @(posedge sys_clk); #1;
      if (d == 0) t0 = cyc;
      fsk_in = count_level(cnt, d);
    end
  endtask

  task automatic wait_valid(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(posedge sys_clk); #1;
      if (rx_valid === 1'b1) found = 1'b1;
    end
  endtask

  task automatic idle_gap();
    fsk_in = 1'b0;
    repeat (QUIET + 20) @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; fsk_in = 1'b0;
    repeat (4) @(posedge sys_clk);
    #1; reset = 1'b0;
    @(posedge sys_clk); #1;
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    checks++; if (crc_ok !== 1'b0) begin failures++; $display("FAIL reset_crc_ok got=%b exp=0", crc_ok); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_byte_bb();
    bit found;
    idle_gap();
    send_tones(12'hBBF, 6, 0, 3);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bb_busy_edge_cycle got=%b exp=0", busy); end
    send_tones(12'hBBF, 6, 3, 4);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bb_busy_after_edge got=%b exp=1", busy); end
    send_tones(12'hBBF, 6, 4, 6*SYM);
    wait_valid(50, found);
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL bb_valid_timeout got=%b exp=1", found); end
    checks++; if (cyc - t0 !== 3 + 6*SYM) begin failures++; $display("FAIL bb_latency got=%0d exp=%0d", cyc - t0, 3 + 6*SYM); end
    checks++; if (rx_data !== 8'hBB) begin failures++; $display("FAIL bb_data got=%h exp=bb", rx_data); end
    checks++; if (crc_ok !== 1'b1) begin failures++; $display("FAIL bb_crc_ok got=%b exp=1", crc_ok); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL bb_frame_err got=%b exp=0", frame_err); end
    @(posedge sys_clk); #1;
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL bb_valid_pulse got=%b exp=0", rx_valid); end
    checks++; if (rx_data !== 8'hBB) begin failures++; $display("FAIL bb_data_hold got=%h exp=bb", rx_data); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bb_busy_quiet got=%b exp=1", busy); end
  endtask

  task automatic test_back_to_back();
    bit found;
    idle_gap();
    send_tones(12'h013, 6, 0, 6*SYM);
    wait_valid(50, found);
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL b2b_first_timeout got=%b exp=1", found); end
    checks++; if (rx_data !== 8'h01) begin failures++; $display("FAIL b2b_first_data got=%h exp=01", rx_data); end
    checks++; if (crc_ok !== 1'b1) begin failures++; $display("FAIL b2b_first_crc got=%b exp=1", crc_ok); end
    idle_gap();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_gap_busy got=%b exp=0", busy); end
    send_tones(12'hBBF, 6, 0, 6*SYM);
    wait_valid(50, found);
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL b2b_second_timeout got=%b exp=1", found); end
    checks++; if (rx_data !== 8'hBB) begin failures++; $display("FAIL b2b_second_data got=%h exp=bb", rx_data); end
    checks++; if (crc_ok !== 1'b1) begin failures++; $display("FAIL b2b_second_crc got=%b exp=1", crc_ok); end
  endtask

  task automatic test_bad_crc();
    bit found;
    idle_gap();
    send_tones(12'hBBE, 6, 0, 6*SYM);
    wait_valid(50, found);
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL badcrc_timeout got=%b exp=1", found); end
    checks++; if (rx_data !== 8'hBB) begin failures++; $display("FAIL badcrc_data got=%h exp=bb", rx_data); end
    checks++; if (crc_ok !== 1'b0) begin failures++; $display("FAIL badcrc_crc_ok got=%b exp=0", crc_ok); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL badcrc_frame_err got=%b exp=0", frame_err); end
  endtask

  task automatic test_carrier_loss();
    bit found;
    idle_gap();
    send_tones(12'hBBF, 3, 0, 3*SYM);
    wait_valid(SYM + 50, found);
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL loss_timeout got=%b exp=1", found); end
    checks++; if (cyc - t0 !== 3 + 4*SYM) begin failures++; $display("FAIL loss_latency got=%0d exp=%0d", cyc - t0, 3 + 4*SYM); end
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL loss_frame_err got=%b exp=1", frame_err); end
    checks++; if (crc_ok !== 1'b0) begin failures++; $display("FAIL loss_crc_ok got=%b exp=0", crc_ok); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL loss_data got=%h exp=00", rx_data); end
    repeat (QUIET) @(posedge sys_clk);
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL loss_busy_before_rearm got=%b exp=1", busy); end
    @(posedge sys_clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL loss_busy_rearmed got=%b exp=0", busy); end
  endtask

  task automatic test_reset_midframe();
    bit found;
    int n0;
    idle_gap();
    n0 = nvalid;
    send_tones(12'hBBF, 6, 0, 3*SYM + SYM/2);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    @(posedge sys_clk); #1;
    reset = 1'b1; fsk_in = 1'b0;
    @(posedge sys_clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL midrst_frame_err got=%b exp=0", frame_err); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h exp=00", rx_data); end
    repeat (2*SYM) @(posedge sys_clk);
    #1;
    checks++; if (nvalid !== n0) begin failures++; $display("FAIL midrst_no_valid got=%0d exp=%0d", nvalid, n0); end
    send_tones(12'hBBF, 6, 0, 6*SYM);
    wait_valid(50, found);
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL midrst_fresh_timeout got=%b exp=1", found); end
    checks++; if (rx_data !== 8'hBB) begin failures++; $display("FAIL midrst_fresh_data got=%h exp=bb", rx_data); end
    checks++; if (crc_ok !== 1'b1) begin failures++; $display("FAIL midrst_fresh_crc got=%b exp=1", crc_ok); end
  endtask

  task automatic test_boundary();
    bit found;
    // Windows 74,75,148,149,148,149 -> symbols 0,1,2,3,2,3 -> data 1B, CRC B (valid).
    idle_gap();
    send_counts({8'd149, 8'd148, 8'd149, 8'd148, 8'd75, 8'd74});
    wait_valid(50, found);
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL bound_a_timeout got=%b exp=1", found); end
    checks++; if (rx_data !== 8'h1B) begin failures++; $display("FAIL bound_a_data got=%h exp=1b", rx_data); end
    checks++; if (crc_ok !== 1'b1) begin failures++; $display("FAIL bound_a_crc got=%b exp=1", crc_ok); end
    // Windows 75,74,149,148,75,74 -> symbols 1,0,3,2,1,0 -> data 4E, CRC field 4 vs true 6.
    idle_gap();
    send_counts({8'd74, 8'd75, 8'd148, 8'd149, 8'd74, 8'd75});
    wait_valid(50, found);
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL bound_b_timeout got=%b exp=1", found); end
    checks++; if (rx_data !== 8'h4E) begin failures++; $display("FAIL bound_b_data got=%h exp=4e", rx_data); end
    checks++; if (crc_ok !== 1'b0) begin failures++; $display("FAIL bound_b_crc got=%b exp=0", crc_ok); end
  endtask

  initial begin
    reset  = 1'b1;
    fsk_in = 1'b0;
    test_reset();
    test_byte_bb();
    test_back_to_back();
    test_bad_crc();
    test_carrier_loss();
    test_reset_midframe();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsk4_crc_receiver.md
Name: fsk4_crc_receiver

Overview:
- Receive end of the CRC-4 / 4FSK byte link: recovers bytes sent by the CRC-4 encoder + 4FSK modulator.
- Input is the 1-bit hard-limited FSK waveform. The block counts rising edges per symbol window to slice each 4FSK tone into 2 bits.
- Reassembles the 12-bit codeword (8 data + 4 CRC) and checks CRC-4.
- Presents the byte with a one-cycle valid strobe, alongside the transmit-side `inputdata`/`next` path in the top level.

Parameters:
- SYMBOL_CYCLES, 4096, clock cycles per symbol window
- THR_01, 75, edge count at or above which the symbol is 1 (below: 0)
- THR_12, 107, edge count at or above which the symbol is 2
- THR_23, 149, edge count at or above which the symbol is 3
- MIN_EDGES, 16, fewer edges in a window means carrier loss
- QUIET_CYCLES, 256, edge-free cycles required before re-arming

Ports:
- sys_clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high reset
- fsk_in  in  1  asynchronous FSK square wave; idle line is constant 0
- rx_data  out  8  received data byte
- rx_valid  out  1  one-cycle strobe: rx_data, crc_ok and frame_err are valid
- crc_ok  out  1  CRC-4 remainder zero
- frame_err  out  1  frame aborted on carrier loss
- busy  out  1  frame reception in progress

Behaviour:
- Reset values: rx_data=0, rx_valid=0, crc_ok=0, frame_err=0, busy=0; FSM in IDLE; all counters 0.
- Input conditioning:
  - fsk_in passes a 2-flop synchronizer, then a delay flop.
  - edge = sync2 & ~prev.
- FSM states: IDLE, RECV, DONE, QUIET.
- IDLE:
  - First edge: enter RECV, window counter=0, symbol index=0, edge count=1 (the starting edge counts in window 0).
  - busy=1 from the cycle after that edge.
- RECV:
  - Window counter runs 0..SYMBOL_CYCLES-1.
  - An edge in the last cycle of a window counts in that window.
  - At window end the count is sliced: below THR_01 gives 0, below THR_12 gives 1, below THR_23 gives 2, else 3.
  - The symbol shifts into the 12-bit shift register, MSB first; edge count restarts at 0 (or 1 if an edge coincides with the first cycle of the next window).
  - Count below MIN_EDGES at any window end: abort to DONE with frame_err=1.
  - After symbol index 5, go to DONE.
- Codeword layout: bits[11:4]=data, MSB first; bits[3:0]=CRC.
- CRC-4: polynomial x^4+x+1, init 0, no reflection, no xorout.
  - The checker runs the LFSR over all 12 bits; crc_ok=1 iff remainder=0.
  - Bits are folded in as symbols arrive, 2 bits per window end.
- DONE (one cycle):
  - rx_valid=1; rx_data=codeword[11:4]; crc_ok and frame_err driven.
  - Abort case: crc_ok=0 and rx_data=0.
  - Next state: QUIET. Latency: rx_valid is the cycle after the final window's last cycle.
- rx_data, crc_ok and frame_err hold until the next DONE. rx_valid is a single-cycle pulse.
- QUIET:
  - busy stays 1.
  - A quiet counter resets on every edge; after QUIET_CYCLES consecutive edge-free cycles, go to IDLE with busy=0.
  - A transmitter still toggling after a frame therefore cannot retrigger mid-tone.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values; no rx_valid for the partial frame.
- Counter widths:
  - Window counter: clog2(SYMBOL_CYCLES).
  - Edge count: saturates at 255 (8 bits).
  - Quiet counter: clog2(QUIET_CYCLES)+1.

Decomposition:
- Package fsk4_crc_pkg holds:
  - the CRC4_POLY constant (4'b0011)
  - the codeword, data and CRC widths (12/8/4)
  - symbols per frame (6)
  - the FSM state enum
  - default thresholds; the transmitter shares these tone and CRC constants.
- Sub-module fsk4_symbol_slicer holds:
  - the synchronizer and edge detector
  - the window counter and edge counter
  - the threshold compare
- It outputs sym[1:0], sym_valid and carrier_lost, one pulse per window end.
- The top holds the FSM, shift register and CRC check.

Test Plan:
- Byte 0xBB (CRC 0xF, symbols 2,3,2,3,3,3), each tone held 4096 cycles at half-periods 32/24/16/12 cycles -> one rx_valid pulse with rx_data=0xBB, crc_ok=1, frame_err=0, about 24577 cycles after the first edge.
- Byte 0x01 (CRC 0x3, symbols 0,0,0,1,0,3) -> rx_data=0x01, crc_ok=1; then a quiet gap; then 0xBB -> second valid byte, busy low in the gap.
- Byte 0xBB sent with CRC 0xE (last symbol 2 instead of 3) -> rx_data=0xBB, crc_ok=0, frame_err=0.
- Tone stopped after symbol 2 (line held 0) -> rx_valid at the end of window 3 with frame_err=1, crc_ok=0, rx_data=0; then IDLE after QUIET_CYCLES.
- Reset pulsed during symbol 3 -> no rx_valid, busy=0 next cycle; a fresh 0xBB frame afterwards decodes correctly.
- Boundary counts 74/75 and 148/149 edges per window -> sliced as 0/1 and 2/3 respectively.
